// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode map and ULA operation codes.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_LW  = 3'b110;
  localparam logic [2:0] OP_BEQ = 3'b111;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_SRL = 2'b10;
  localparam logic [1:0] ULA_SLL = 2'b11;

  // slt shares the sll/compare encoding; memory and branch opcodes fall back to add
  function automatic logic [1:0] ula_op_for(input logic [2:0] opcode);
    logic [1:0] op_s;
    case (opcode)
      OP_ADD:  op_s = ULA_ADD;
      OP_SUB:  op_s = ULA_SUB;
      OP_SRL:  op_s = ULA_SRL;
      OP_SLL:  op_s = ULA_SLL;
      OP_SLT:  op_s = ULA_SLL;
      default: op_s = ULA_ADD;
    endcase
    return op_s;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Wait-state counter for memory accesses; flags the cycle on which the timeout budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Wait counter: clear dominates, otherwise count idle memory cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // The MEM_TIMEOUT-th unanswered cycle is the one that trips the timeout
  always_comb begin
    timeout = inc && (count_r == LAST_WAIT);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: fetch/decode/execute sequencing with memory handshake and timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] OPcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegMemWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ULAOp,
  output logic       error,
  output logic [2:0] state
);

  state_t state_r;
  state_t state_next_s;
  logic   waiting_s;
  logic   timeout_s;
  logic   clr_s;

  // Only FETCH and MEM wait on memory; any state change restarts the count
  always_comb begin
    waiting_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
    clr_s     = (state_next_s != state_r) || !waiting_s;
  end

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mem_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr_s),
    .inc     (waiting_s && !mem_ready),
    .timeout (timeout_s)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          state_next_s = ST_DECODE;
        end else if (timeout_s) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (OPcode == OP_BEQ) begin
          state_next_s = ST_BRANCH;
        end else if ((OPcode == OP_SW) || (OPcode == OP_LW)) begin
          state_next_s = ST_MEM;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_EXEC:   state_next_s = ST_WB;
      ST_WB:     state_next_s = ST_FETCH;
      ST_BRANCH: state_next_s = ST_FETCH;
      ST_MEM: begin
        if (mem_ready) begin
          state_next_s = ST_FETCH;
        end else if (timeout_s) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_ERROR:  state_next_s = ST_ERROR;
      default:   state_next_s = ST_ERROR;
    endcase
  end

  // Output decode; reset forces every strobe low even though the state already reads FETCH
  always_comb begin
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegMemWrite = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Branch      = 1'b0;
    ULAOp       = ULA_ADD;
    error       = 1'b0;
    if (reset) begin
      error = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        ST_EXEC:   ULAOp = ula_op_for(OPcode);
        ST_WB:     RegWrite = (OPcode[2] == 1'b0);
        ST_MEM: begin
          if (OPcode == OP_SW) begin
            MemWrite = 1'b1;
          end else begin
            MemRead     = 1'b1;
            RegMemWrite = mem_ready;
          end
        end
        ST_BRANCH: begin
          ULAOp   = ULA_SLL;
          Branch  = 1'b1;
          PCWrite = zero;
        end
        ST_ERROR:  error = 1'b1;
        default:   error = 1'b0;
      endcase
    end
  end

  assign state = state_r;

endmodule
